sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Single owner of the external asynchronous SRAM; shares it between the VGA display fetch (read port) and the triangle rasterizer point store (write port).
- Sequences every access with fixed-timing states so WE_N/OE_N/DQ never conflict.
- Display reads have priority; a streak limit guarantees the rasterizer forward progress.
- Counts completed writes so the draw logic knows how many points are stored.

Parameters:
- AW, 18, SRAM address width.
- DW, 16, SRAM data width.
- RD_WAIT, 2, cycles OE_N is held low per read (>=1); data captured at the closing edge of the last one.
- MAX_RD_STREAK, 4, consecutive read grants allowed while wr_valid is pending before a write is forced.

Ports:
- CLOCK_50  in  1  system clock, all state on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- rd_req  in  1  read request, level; held high with rd_addr stable until rd_ack.
- rd_addr  in  AW  read address.
- rd_ack  out  1  one-cycle pulse, rd_data valid this cycle.
- rd_data  out  DW  registered read data; holds until next capture.
- wr_valid  in  1  write request valid.
- wr_addr  in  AW  write address.
- wr_data  in  DW  write data.
- wr_ready  out  1  combinational; transfer when wr_valid & wr_ready.
- wr_done  out  1  one-cycle pulse when a write cycle completes (end of WR_HOLD).
- wr_count  out  AW  completed writes since reset/clear, saturates at all-ones.
- cnt_clr  in  1  synchronous clear of wr_count; wins over a simultaneous increment.
- busy  out  1  high in any state other than IDLE.
- SRAM_ADDR  out  AW  registered address.
- SRAM_DQ  inout  DW  driven only in WR_SETUP/WR_PULSE/WR_HOLD, else high-Z.
- SRAM_WE_N, SRAM_OE_N, SRAM_CE_N  out  1 each  active-low strobes, registered.
- SRAM_UB_N, SRAM_LB_N  out  1 each  tied 0 (full-word access).

Behaviour:
- States: IDLE, RD (RD_WAIT cycles, internal wait counter), RD_ACK, WR_SETUP, WR_PULSE, WR_HOLD.
- Reset (async, any state): state=IDLE; SRAM_WE_N=1, SRAM_OE_N=1, SRAM_CE_N=1, DQ high-Z, SRAM_ADDR=0; rd_ack=0, rd_data=0, wr_done=0, wr_count=0, busy=0, streak=0. An access in flight is abandoned with no ack/done.
- IDLE arbitration at each edge:
  - rd_req & (streak<MAX_RD_STREAK or !wr_valid) -> RD; latch rd_addr; streak++ if wr_valid, else streak=0.
  - else if wr_valid -> WR_SETUP; latch wr_addr/wr_data; streak=0.
  - wr_ready = (state==IDLE) & wr_valid-independent grant condition: !(rd_req & streak<MAX_RD_STREAK).
- RD: CE_N=0, OE_N=0, WE_N=1. At the final RD cycle edge, rd_data<=SRAM_DQ, go RD_ACK.
- RD_ACK: rd_ack=1, OE_N=1, CE_N=1; next IDLE. Latency rd_req sampled -> rd_ack high = RD_WAIT+1 cycles (3 at default); back-to-back read every RD_WAIT+2 cycles.
- WR_SETUP: CE_N=0, addr+DQ driven, WE_N=1. WR_PULSE: WE_N=0. WR_HOLD: WE_N=1, DQ/addr still driven, wr_done=1, wr_count++ (unless saturated or cnt_clr). Next IDLE. Write occupies 3 cycles + 1 IDLE.
- OE_N and WE_N are never low together; DQ never driven while OE_N=0.
- Requester dropping rd_req mid-read: read completes, rd_ack still pulses; requester ignores.
- wr_valid dropped before handshake: no write. Inputs sampled only at grant edge.

Test Plan:
- Reset: RESET_N low mid-WR_PULSE -> WE_N=1, DQ=Z, wr_done never pulses, wr_count=0 immediately (async).
- Single read: SRAM model holds 0x1234 at 0x00010; rd_req at edge 0 -> rd_ack high at cycle 3, rd_data=0x1234, OE_N low exactly cycles 1-2.
- Single write: wr_valid, addr 0x0000F, data 0xABCD -> WE_N low exactly 1 cycle, DQ=0xABCD cycles 1-3, wr_done at cycle 3, wr_count=1, model holds 0xABCD.
- Contention: rd_req and wr_valid held continuously -> grants repeat 4 reads then 1 write; no strobe overlap (assertion on OE_N|WE_N).
- Streak reset: write pending, 2 reads, rd_req drops -> write granted, streak=0; next 4 reads granted before a write.
- Counter: 5 writes, cnt_clr pulsed coincident with 5th wr_done -> wr_count=0; force 0x3FFFF and write -> stays 0x3FFFF.

Source files
------------

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sram_port_arbiter
//  Purpose  : Sole owner of the external asynchronous SRAM. Shares it between
//             the display fetch (read port, priority) and the rasterizer point
//             store (write port). Every access runs through fixed-timing states
//             so the WE_N, OE_N and DQ drivers can never conflict. A read-streak
//             limit forces a pending write through after MAX_RD_STREAK reads.
//             Completed writes are counted (saturating).
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLOCK_50, RESET_N        clock (rising edge), async active-low reset
//    rd_req/rd_addr           level read request, held until rd_ack
//    rd_ack/rd_data           one-cycle ack, registered read data (holds)
//    wr_valid/wr_addr/wr_data write request, transfers on wr_valid & wr_ready
//    wr_ready                 combinational write grant
//    wr_done                  one-cycle pulse during the write hold cycle
//    wr_count/cnt_clr         saturating completed-write count, sync clear
//    busy                     arbiter not idle
//    SRAM_*                   registered SRAM strobes/address, shared DQ bus
// ============================================================================
module sram_port_arbiter #(
  parameter int AW            = 18,
  parameter int DW            = 16,
  parameter int RD_WAIT       = 2,
  parameter int MAX_RD_STREAK = 4
) (
  input  logic          CLOCK_50,
  input  logic          RESET_N,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_ack,
  output logic [DW-1:0] rd_data,
  input  logic          wr_valid,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic          wr_done,
  output logic [AW-1:0] wr_count,
  input  logic          cnt_clr,
  output logic          busy,
  output logic [AW-1:0] SRAM_ADDR,
  inout  wire  [DW-1:0] SRAM_DQ,
  output logic          SRAM_WE_N,
  output logic          SRAM_OE_N,
  output logic          SRAM_CE_N,
  output logic          SRAM_UB_N,
  output logic          SRAM_LB_N
);

  localparam int c_STREAK_W = $clog2(MAX_RD_STREAK + 1);
  localparam int c_WAIT_W   = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
  localparam logic [c_STREAK_W-1:0] c_MAX_STREAK = c_STREAK_W'(MAX_RD_STREAK);
  localparam logic [c_WAIT_W-1:0]   c_WAIT_LAST  = c_WAIT_W'(RD_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD       = 3'd1,
    S_RD_ACK   = 3'd2,
    S_WR_SETUP = 3'd3,
    S_WR_PULSE = 3'd4,
    S_WR_HOLD  = 3'd5
  } state_t;

  state_t                  r_state;
  logic [c_STREAK_W-1:0]   r_streak;
  logic [c_WAIT_W-1:0]     r_wait;
  logic [AW-1:0]           r_addr;
  logic [DW-1:0]           r_wdata;
  logic                    r_dq_oe;
  logic                    r_we_n;
  logic                    r_oe_n;
  logic                    r_ce_n;
  logic                    r_rd_ack;
  logic [DW-1:0]           r_rd_data;
  logic                    r_wr_done;
  logic [AW-1:0]           r_wr_count;

  // A read wins outright while under the streak limit; once the limit is hit
  // it only wins if no write is waiting.
  logic w_rd_under_limit;
  logic w_rd_grant;

  assign w_rd_under_limit = rd_req & (r_streak < c_MAX_STREAK);
  assign w_rd_grant       = rd_req & ((r_streak < c_MAX_STREAK) | ~wr_valid);

  assign wr_ready  = (r_state == S_IDLE) & ~w_rd_under_limit;
  assign busy      = (r_state != S_IDLE);
  assign rd_ack    = r_rd_ack;
  assign rd_data   = r_rd_data;
  assign wr_done   = r_wr_done;
  assign wr_count  = r_wr_count;
  assign SRAM_ADDR = r_addr;
  assign SRAM_WE_N = r_we_n;
  assign SRAM_OE_N = r_oe_n;
  assign SRAM_CE_N = r_ce_n;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_DQ   = r_dq_oe ? r_wdata : {DW{1'bz}};

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= S_IDLE;
      r_streak   <= '0;
      r_wait     <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_dq_oe    <= 1'b0;
      r_we_n     <= 1'b1;
      r_oe_n     <= 1'b1;
      r_ce_n     <= 1'b1;
      r_rd_ack   <= 1'b0;
      r_rd_data  <= '0;
      r_wr_done  <= 1'b0;
      r_wr_count <= '0;
    end else begin
      r_rd_ack  <= 1'b0;
      r_wr_done <= 1'b0;
      if (cnt_clr) begin
        r_wr_count <= '0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_rd_grant) begin
            r_state  <= S_RD;
            r_addr   <= rd_addr;
            r_ce_n   <= 1'b0;
            r_oe_n   <= 1'b0;
            r_wait   <= c_WAIT_LAST;
            // Only reads that bypass a waiting write count toward the streak.
            r_streak <= wr_valid ? (r_streak + 1'b1) : '0;
          end else if (wr_valid) begin
            r_state  <= S_WR_SETUP;
            r_addr   <= wr_addr;
            r_wdata  <= wr_data;
            r_ce_n   <= 1'b0;
            r_dq_oe  <= 1'b1;
            r_streak <= '0;
          end
        end
        S_RD: begin
          if (r_wait == '0) begin
            r_rd_data <= SRAM_DQ;
            r_rd_ack  <= 1'b1;
            r_oe_n    <= 1'b1;
            r_ce_n    <= 1'b1;
            r_state   <= S_RD_ACK;
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end
        S_RD_ACK: begin
          r_state <= S_IDLE;
        end
        S_WR_SETUP: begin
          r_we_n  <= 1'b0;
          r_state <= S_WR_PULSE;
        end
        S_WR_PULSE: begin
          // Data is latched by the SRAM on this WE_N rising edge; DQ stays
          // driven through WR_HOLD for hold time.
          r_we_n    <= 1'b1;
          r_wr_done <= 1'b1;
          r_state   <= S_WR_HOLD;
        end
        S_WR_HOLD: begin
          r_ce_n  <= 1'b1;
          r_dq_oe <= 1'b0;
          r_state <= S_IDLE;
          // Count lands as the hold cycle closes; a clear on the same edge wins.
          if (!cnt_clr && (r_wr_count != '1)) begin
            r_wr_count <= r_wr_count + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_we_n  <= 1'b1;
          r_oe_n  <= 1'b1;
          r_ce_n  <= 1'b1;
          r_dq_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_port_arbiter
//  Purpose  : Directed self-checking bench for sram_port_arbiter with a small
//             behavioural asynchronous SRAM on the DQ bus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_port_arbiter;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N;
  logic        rd_req;
  logic [17:0] rd_addr;
  logic        rd_ack;
  logic [15:0] rd_data;
  logic        wr_valid;
  logic [17:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic        wr_done;
  logic [17:0] wr_count;
  logic        cnt_clr;
  logic        busy;
  logic [17:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;
  logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;

  int n_cmp  = 0;
  int n_fail = 0;
  logic mon_en = 1'b0;

  logic [15:0] mem [0:1023];

  always #10 CLOCK_50 = ~CLOCK_50;

  sram_port_arbiter dut (
    .CLOCK_50 (CLOCK_50), .RESET_N (RESET_N),
    .rd_req   (rd_req),   .rd_addr (rd_addr), .rd_ack (rd_ack), .rd_data (rd_data),
    .wr_valid (wr_valid), .wr_addr (wr_addr), .wr_data (wr_data), .wr_ready (wr_ready),
    .wr_done  (wr_done),  .wr_count (wr_count), .cnt_clr (cnt_clr), .busy (busy),
    .SRAM_ADDR (SRAM_ADDR), .SRAM_DQ (SRAM_DQ),
    .SRAM_WE_N (SRAM_WE_N), .SRAM_OE_N (SRAM_OE_N), .SRAM_CE_N (SRAM_CE_N),
    .SRAM_UB_N (SRAM_UB_N), .SRAM_LB_N (SRAM_LB_N)
  );

  // Behavioural async SRAM: drives DQ on read, latches on WE_N rising edge.
  assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR[9:0]] : 16'hzzzz;
  always @(posedge SRAM_WE_N) if (!SRAM_CE_N) mem[SRAM_ADDR[9:0]] = SRAM_DQ;

  // Strobe exclusivity watcher, enabled during the contention scenario.
  always @(negedge CLOCK_50) begin
    if (mon_en) begin
      n_cmp++;
      if (!SRAM_OE_N && !SRAM_WE_N) begin
        n_fail++;
        $display("FAIL strobe_overlap OE_N=%b WE_N=%b want not both 0", SRAM_OE_N, SRAM_WE_N);
      end
    end
  end

  // Waits for the next access grant (CE_N falling) and reports its type.
  task automatic wait_grant(output byte g);
    logic prev_ce;
    g = "T";
    prev_ce = SRAM_CE_N;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLOCK_50);
      if (prev_ce && !SRAM_CE_N) begin
        g = SRAM_OE_N ? "W" : "R";
        break;
      end
      prev_ce = SRAM_CE_N;
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; rd_req = 1'b0; rd_addr = '0; wr_valid = 1'b0;
    wr_addr = '0; wr_data = '0; cnt_clr = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    n_cmp++; if (SRAM_WE_N !== 1'b1) begin n_fail++; $display("FAIL rst_we_n got=%b want=1", SRAM_WE_N); end
    n_cmp++; if (SRAM_OE_N !== 1'b1) begin n_fail++; $display("FAIL rst_oe_n got=%b want=1", SRAM_OE_N); end
    n_cmp++; if (SRAM_CE_N !== 1'b1) begin n_fail++; $display("FAIL rst_ce_n got=%b want=1", SRAM_CE_N); end
    n_cmp++; if (SRAM_ADDR !== 18'h0) begin n_fail++; $display("FAIL rst_addr got=%h want=0", SRAM_ADDR); end
    n_cmp++; if (rd_ack !== 1'b0 || wr_done !== 1'b0) begin n_fail++; $display("FAIL rst_pulses got=%b%b want=00", rd_ack, wr_done); end
    n_cmp++; if (rd_data !== 16'h0) begin n_fail++; $display("FAIL rst_rd_data got=%h want=0", rd_data); end
    n_cmp++; if (wr_count !== 18'h0) begin n_fail++; $display("FAIL rst_wr_count got=%h want=0", wr_count); end
    n_cmp++; if (SRAM_UB_N !== 1'b0 || SRAM_LB_N !== 1'b0) begin n_fail++; $display("FAIL rst_ub_lb got=%b%b want=00", SRAM_UB_N, SRAM_LB_N); end
    RESET_N = 1'b1;
    @(negedge CLOCK_50);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b want=0", busy); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wr_ready got=%b want=1", wr_ready); end
  endtask

  task automatic test_single_read();
    mem[16] = 16'h1234;
    rd_req = 1'b1; rd_addr = 18'h00010;
    #1;
    n_cmp++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL rd_wr_ready got=%b want=0", wr_ready); end
    @(negedge CLOCK_50); // cycle 1
    n_cmp++; if (SRAM_OE_N !== 1'b0 || SRAM_CE_N !== 1'b0) begin n_fail++; $display("FAIL rd_c1_strobes got=%b%b want=00", SRAM_OE_N, SRAM_CE_N); end
    n_cmp++; if (SRAM_ADDR !== 18'h00010) begin n_fail++; $display("FAIL rd_addr got=%h want=00010", SRAM_ADDR); end
    n_cmp++; if (busy !== 1'b1 || rd_ack !== 1'b0) begin n_fail++; $display("FAIL rd_c1_busy_ack got=%b%b want=10", busy, rd_ack); end
    @(negedge CLOCK_50); // cycle 2
    n_cmp++; if (SRAM_OE_N !== 1'b0 || rd_ack !== 1'b0) begin n_fail++; $display("FAIL rd_c2 oe_n/ack got=%b%b want=00", SRAM_OE_N, rd_ack); end
    @(negedge CLOCK_50); // cycle 3
    n_cmp++; if (rd_ack !== 1'b1) begin n_fail++; $display("FAIL rd_ack_c3 got=%b want=1", rd_ack); end
    n_cmp++; if (rd_data !== 16'h1234) begin n_fail++; $display("FAIL rd_data got=%h want=1234", rd_data); end
    n_cmp++; if (SRAM_OE_N !== 1'b1) begin n_fail++; $display("FAIL rd_c3_oe_n got=%b want=1", SRAM_OE_N); end
    rd_req = 1'b0;
    @(negedge CLOCK_50); // cycle 4
    n_cmp++; if (rd_ack !== 1'b0 || rd_data !== 16'h1234) begin n_fail++; $display("FAIL rd_c4 ack=%b data=%h want 0/1234", rd_ack, rd_data); end
  endtask

  task automatic test_single_write();
    wr_valid = 1'b1; wr_addr = 18'h0000F; wr_data = 16'hABCD;
    #1;
    n_cmp++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready got=%b want=1", wr_ready); end
    @(negedge CLOCK_50); // cycle 1
    wr_valid = 1'b0;
    n_cmp++; if (SRAM_WE_N !== 1'b1 || SRAM_CE_N !== 1'b0) begin n_fail++; $display("FAIL wr_c1 we_n/ce_n got=%b%b want=10", SRAM_WE_N, SRAM_CE_N); end
    n_cmp++; if (SRAM_DQ !== 16'hABCD || SRAM_ADDR !== 18'h0000F) begin n_fail++; $display("FAIL wr_c1 dq=%h addr=%h want ABCD/0000F", SRAM_DQ, SRAM_ADDR); end
    @(negedge CLOCK_50); // cycle 2
    n_cmp++; if (SRAM_WE_N !== 1'b0 || SRAM_DQ !== 16'hABCD) begin n_fail++; $display("FAIL wr_c2 we_n=%b dq=%h want 0/ABCD", SRAM_WE_N, SRAM_DQ); end
    @(negedge CLOCK_50); // cycle 3
    n_cmp++; if (SRAM_WE_N !== 1'b1 || SRAM_DQ !== 16'hABCD) begin n_fail++; $display("FAIL wr_c3 we_n=%b dq=%h want 1/ABCD", SRAM_WE_N, SRAM_DQ); end
    n_cmp++; if (wr_done !== 1'b1) begin n_fail++; $display("FAIL wr_done_c3 got=%b want=1", wr_done); end
    @(negedge CLOCK_50); // cycle 4
    n_cmp++; if (wr_done !== 1'b0 || dut.r_dq_oe !== 1'b0) begin n_fail++; $display("FAIL wr_c4 done=%b dq_oe=%b want 0/0", wr_done, dut.r_dq_oe); end
    n_cmp++; if (wr_count !== 18'd1) begin n_fail++; $display("FAIL wr_count got=%h want=1", wr_count); end
    n_cmp++; if (mem[15] !== 16'hABCD) begin n_fail++; $display("FAIL wr_mem got=%h want=ABCD", mem[15]); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_c4_busy got=%b want=0", busy); end
  endtask

  task automatic test_reset_mid_write();
    wr_valid = 1'b1; wr_addr = 18'h00020; wr_data = 16'h5555;
    @(negedge CLOCK_50); // WR_SETUP
    wr_valid = 1'b0;
    @(negedge CLOCK_50); // WR_PULSE
    n_cmp++; if (SRAM_WE_N !== 1'b0) begin n_fail++; $display("FAIL mrst_pulse_we_n got=%b want=0", SRAM_WE_N); end
    RESET_N = 1'b0;
    #1;
    n_cmp++; if (SRAM_WE_N !== 1'b1 || SRAM_CE_N !== 1'b1) begin n_fail++; $display("FAIL mrst_strobes we_n=%b ce_n=%b want 1/1", SRAM_WE_N, SRAM_CE_N); end
    n_cmp++; if (dut.r_dq_oe !== 1'b0) begin n_fail++; $display("FAIL mrst_dq_drive got=%b want=0", dut.r_dq_oe); end
    n_cmp++; if (wr_count !== 18'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL mrst_count_busy cnt=%h busy=%b want 0/0", wr_count, busy); end
    for (int i = 0; i < 6; i++) begin
      @(negedge CLOCK_50);
      if (i == 2) RESET_N = 1'b1;
      n_cmp++; if (wr_done !== 1'b0) begin n_fail++; $display("FAIL mrst_no_done cyc=%0d got=%b want=0", i, wr_done); end
    end
    n_cmp++; if (busy !== 1'b0 || wr_count !== 18'd0) begin n_fail++; $display("FAIL mrst_after busy=%b cnt=%h want 0/0", busy, wr_count); end
  endtask

  task automatic test_contention();
    byte g;
    byte exp_seq [10] = '{"R","R","R","R","W","R","R","R","R","W"};
    rd_req = 1'b1; rd_addr = 18'h00010;
    wr_valid = 1'b1; wr_addr = 18'h00040; wr_data = 16'h0F0F;
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_grant(g);
      n_cmp++; if (g !== exp_seq[i]) begin n_fail++; $display("FAIL contention_grant%0d got=%c want=%c", i, g, exp_seq[i]); end
    end
    rd_req = 1'b0; wr_valid = 1'b0;
    repeat (6) @(negedge CLOCK_50);
    mon_en = 1'b0;
  endtask

  task automatic test_streak_reset();
    byte g;
    byte exp_seq [5] = '{"R","R","R","R","W"};
    bit  got_ack;
    rd_req = 1'b1; rd_addr = 18'h00010;
    wr_valid = 1'b1; wr_addr = 18'h00041; wr_data = 16'h1111;
    for (int i = 0; i < 2; i++) begin
      wait_grant(g);
      n_cmp++; if (g !== "R") begin n_fail++; $display("FAIL streak_pre_read%0d got=%c want=R", i, g); end
    end
    got_ack = 1'b0;
    for (int i = 0; i < 10 && !got_ack; i++) begin
      @(negedge CLOCK_50);
      got_ack = rd_ack;
    end
    n_cmp++; if (got_ack !== 1'b1) begin n_fail++; $display("FAIL streak_rd_ack_timeout got=%b want=1", got_ack); end
    rd_req = 1'b0;
    @(negedge CLOCK_50); // IDLE with only the write pending
    n_cmp++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL streak_wr_ready got=%b want=1", wr_ready); end
    wait_grant(g);
    n_cmp++; if (g !== "W") begin n_fail++; $display("FAIL streak_write_grant got=%c want=W", g); end
    rd_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_grant(g);
      n_cmp++; if (g !== exp_seq[i]) begin n_fail++; $display("FAIL streak_post_grant%0d got=%c want=%c", i, g, exp_seq[i]); end
    end
    rd_req = 1'b0; wr_valid = 1'b0;
    repeat (6) @(negedge CLOCK_50);
  endtask

  task automatic test_counter();
    int dones;
    dones = 0;
    cnt_clr = 1'b1;
    @(negedge CLOCK_50);
    cnt_clr = 1'b0;
    wr_valid = 1'b1; wr_addr = 18'h00100; wr_data = 16'h0001;
    for (int i = 0; i < 40 && dones < 5; i++) begin
      @(negedge CLOCK_50);
      if (wr_done) begin
        dones++;
        if (dones == 4) begin
          n_cmp++; if (wr_count !== 18'd3) begin n_fail++; $display("FAIL cnt_at_done4 got=%h want=3", wr_count); end
        end
        if (dones == 5) begin
          n_cmp++; if (wr_count !== 18'd4) begin n_fail++; $display("FAIL cnt_at_done5 got=%h want=4", wr_count); end
          cnt_clr = 1'b1; wr_valid = 1'b0;
        end
      end
    end
    n_cmp++; if (dones != 5) begin n_fail++; $display("FAIL cnt_done_pulses got=%0d want=5", dones); end
    @(negedge CLOCK_50);
    cnt_clr = 1'b0;
    n_cmp++; if (wr_count !== 18'd0) begin n_fail++; $display("FAIL cnt_clr_wins got=%h want=0", wr_count); end
    // Saturation: preload the counter, then complete one more write.
    dut.r_wr_count = 18'h3FFFF;
    @(negedge CLOCK_50);
    n_cmp++; if (wr_count !== 18'h3FFFF) begin n_fail++; $display("FAIL cnt_preload got=%h want=3FFFF", wr_count); end
    wr_valid = 1'b1; wr_addr = 18'h00101; wr_data = 16'h0002;
    dones = 0;
    for (int i = 0; i < 10 && dones == 0; i++) begin
      @(negedge CLOCK_50);
      if (busy) wr_valid = 1'b0;
      if (wr_done) dones = 1;
    end
    n_cmp++; if (dones != 1) begin n_fail++; $display("FAIL sat_done_timeout got=%0d want=1", dones); end
    @(negedge CLOCK_50);
    n_cmp++; if (wr_count !== 18'h3FFFF) begin n_fail++; $display("FAIL cnt_saturate got=%h want=3FFFF", wr_count); end
    n_cmp++; if (mem[257] !== 16'h0002) begin n_fail++; $display("FAIL sat_mem got=%h want=0002", mem[257]); end
    cnt_clr = 1'b1;
    @(negedge CLOCK_50);
    cnt_clr = 1'b0;
    n_cmp++; if (wr_count !== 18'd0) begin n_fail++; $display("FAIL cnt_clr_idle got=%h want=0", wr_count); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_reset_mid_write();
    test_contention();
    test_streak_reset();
    test_counter();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached at %0t want finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
